// File: rtl/proc_run_ctrl.sv
// Run controller for the processor core: mode latch, core reset sequencing, clock-enable gating, cycle counting.
// Optional feature macro: RUNCTRL_WATCHDOG_EN (forces DONE with timeout after WDOG_LIMIT enabled cycles).
module proc_run_ctrl #(
  parameter int MODE_W     = 5,
  parameter int CNT_W      = 16,
  parameter int RST_CYCLES = 2,
  parameter int WDOG_LIMIT = 1000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              pause,
  input  logic              step,
  input  logic [MODE_W-1:0] mode_in,
  input  logic              halt_in,
  output logic              proc_rstn,
  output logic              proc_en,
  output logic [MODE_W-1:0] mode_out,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  if (RST_CYCLES < 1) begin : g_bad_rst
    $error("proc_run_ctrl: RST_CYCLES must be >= 1");
  end
  if (WDOG_LIMIT < 1) begin : g_bad_wdog
    $error("proc_run_ctrl: WDOG_LIMIT must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RESET = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    STEP  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t            state;
  state_t            nxt;
  logic              step_q;
  logic [RC_W-1:0]   rst_cnt;
  logic              wdog_hit;
  logic              accept_start;

  assign accept_start = ((state == IDLE) || (state == DONE)) && start;

`ifdef RUNCTRL_WATCHDOG_EN
  assign wdog_hit = (state == RUN) && proc_en && (cycle_cnt == CNT_W'(WDOG_LIMIT - 1));

  // halt_in outranks the watchdog, so a same-cycle halt leaves timeout clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      timeout <= 1'b0;
    end else if (accept_start) begin
      timeout <= 1'b0;
    end else if (wdog_hit && !halt_in) begin
      timeout <= 1'b1;
    end
  end
`else
  assign wdog_hit = 1'b0;
  assign timeout  = 1'b0;
`endif

  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: if (start) nxt = RESET;
      RESET:      if (rst_cnt == RC_W'(RST_CYCLES - 1)) nxt = pause ? PAUSE : RUN;
      RUN: begin
        if (halt_in)       nxt = DONE;
        else if (wdog_hit) nxt = DONE;
        else if (pause)    nxt = PAUSE;
      end
      PAUSE: begin
        if (!pause)                nxt = RUN;
        else if (step && !step_q)  nxt = STEP;
      end
      STEP:    nxt = halt_in ? DONE : PAUSE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      step_q    <= 1'b0;
      rst_cnt   <= '0;
      proc_rstn <= 1'b0;
      proc_en   <= 1'b0;
      mode_out  <= '0;
      cycle_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= nxt;
      step_q    <= step;
      proc_en   <= (nxt == RUN) || (nxt == STEP);
      proc_rstn <= !((nxt == IDLE) || (nxt == RESET));
      busy      <= (nxt == RESET) || (nxt == RUN) || (nxt == PAUSE) || (nxt == STEP);
      done      <= (nxt == DONE);
      if (accept_start) begin
        mode_out  <= mode_in;
        cycle_cnt <= '0;
        rst_cnt   <= '0;
      end else begin
        if (proc_en && (cycle_cnt != '1)) cycle_cnt <= cycle_cnt + 1'b1;
        if (state == RESET) rst_cnt <= rst_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Scoreboarded random/directed bench for proc_run_ctrl against a flag-based behavioural model.
module tb_proc_run_ctrl;

  localparam int MODE_W     = 5;
  localparam int CNT_W      = 5;
  localparam int RST_CYCLES = 2;
  localparam int WDOG_LIMIT = 20;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;
`ifdef RUNCTRL_WATCHDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0, pause = 1'b0, step = 1'b0, halt_in = 1'b0;
  logic [MODE_W-1:0] mode_in = '0;
  logic              proc_rstn, proc_en, busy, done, timeout;
  logic [MODE_W-1:0] mode_out;
  logic [CNT_W-1:0]  cycle_cnt;

  proc_run_ctrl #(.MODE_W(MODE_W), .CNT_W(CNT_W), .RST_CYCLES(RST_CYCLES), .WDOG_LIMIT(WDOG_LIMIT)) dut (
    .clk(clk), .rstn(rstn), .start(start), .pause(pause), .step(step), .mode_in(mode_in),
    .halt_in(halt_in), .proc_rstn(proc_rstn), .proc_en(proc_en), .mode_out(mode_out),
    .cycle_cnt(cycle_cnt), .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              rstn_o;
    logic              en;
    logic [MODE_W-1:0] mode;
    logic [CNT_W-1:0]  cnt;
    logic              busy_o;
    logic              done_o;
    logic              to;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Model: a run is "active" from accepted start until it finishes; within it the
  // core is either held in reset (rst_left>0), running, paused, or taking one step.
  bit          m_active, m_paused, m_stepping, m_done, m_timeout, m_prev_step;
  int          m_rst_left, m_cnt;
  logic [MODE_W-1:0] m_mode;

  function automatic bit model_en();
    return m_active && (m_rst_left == 0) && (!m_paused || m_stepping);
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.rstn_o = (m_active && m_rst_left == 0) || m_done;
    e.en     = model_en();
    e.mode   = m_mode;
    e.cnt    = CNT_W'(m_cnt);
    e.busy_o = m_active;
    e.done_o = m_done;
    e.to     = m_timeout;
    return e;
  endfunction

  task automatic model_clear();
    m_active = 0; m_paused = 0; m_stepping = 0; m_done = 0; m_timeout = 0;
    m_prev_step = 0; m_rst_left = 0; m_cnt = 0; m_mode = '0;
  endtask

  task automatic finish_run(input bit by_wdog);
    m_active = 0; m_paused = 0; m_stepping = 0; m_done = 1; m_timeout = by_wdog;
  endtask

  // One clock edge of the model using the inputs currently applied.
  task automatic model_edge();
    int old_cnt;
    old_cnt = m_cnt;
    if (model_en() && m_cnt < CNT_MAX) m_cnt++;
    if (!m_active) begin
      if (start) begin
        m_mode = mode_in; m_cnt = 0; m_timeout = 0; m_done = 0;
        m_active = 1; m_rst_left = RST_CYCLES; m_paused = 0; m_stepping = 0;
      end
    end else if (m_rst_left > 0) begin
      m_rst_left--;
      if (m_rst_left == 0) m_paused = pause;
    end else if (m_stepping) begin
      if (halt_in) finish_run(0);
      else m_stepping = 0;
    end else if (m_paused) begin
      if (!pause) m_paused = 0;
      else if (step && !m_prev_step) m_stepping = 1;
    end else begin
      if (halt_in) finish_run(0);
      else if (WDOG_ON && old_cnt == WDOG_LIMIT - 1) finish_run(1);
      else if (pause) m_paused = 1;
    end
    m_prev_step = step;
    exp_q.push_back(model_out());
  endtask

  task automatic cyc(input bit s, input bit p, input bit st, input bit h, input logic [MODE_W-1:0] md);
    @(negedge clk);
    start = s; pause = p; step = st; halt_in = h; mode_in = md;
    model_edge();
  endtask

  task automatic check_reset_vals(input string tag);
    exp_t got;
    got = '{proc_rstn, proc_en, mode_out, cycle_cnt, busy, done, timeout};
    total++;
    if (got !== exp_t'(0)) begin
      bad++;
      $display("FAIL %s: got rstn=%b en=%b mode=%h cnt=%0d busy=%b done=%b to=%b, want all zero",
               tag, proc_rstn, proc_en, mode_out, cycle_cnt, busy, done, timeout);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rstn = 1'b0; start = 0; pause = 0; step = 0; halt_in = 0; mode_in = '0;
    model_clear();
    #2 check_reset_vals("async_reset");
    repeat (n) @(negedge clk);
    check_reset_vals("reset_hold");
    rstn = 1'b1;
    model_edge();
  endtask

  // Monitor: every cycle the DUT presents a new registered output set.
  initial begin
    exp_t e, got;
    forever begin
      @(posedge clk);
      #1;
      if (rstn && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = '{proc_rstn, proc_en, mode_out, cycle_cnt, busy, done, timeout};
        total++;
        if (got !== e) begin
          bad++;
          $display("FAIL outputs t=%0t: got rstn=%b en=%b mode=%h cnt=%0d busy=%b done=%b to=%b, want rstn=%b en=%b mode=%h cnt=%0d busy=%b done=%b to=%b",
                   $time, got.rstn_o, got.en, got.mode, got.cnt, got.busy_o, got.done_o, got.to,
                   e.rstn_o, e.en, e.mode, e.cnt, e.busy_o, e.done_o, e.to);
        end
      end
    end
  end

  initial begin
    bit p_lvl;
    model_clear();
    #1;
    check_reset_vals("power_on");
    do_reset(5);
    repeat (3) cyc(0, 0, 0, 0, '0);
    // start with all-ones mode, two reset cycles, then ten run cycles
    cyc(1, 0, 0, 0, 5'b11111);
    repeat (12) cyc(0, 0, 0, 0, 5'b00000);
    // pause for five cycles then release
    repeat (5) cyc(0, 1, 0, 0, '0);
    repeat (3) cyc(0, 0, 0, 0, '0);
    // single-step with a held step, then a second edge
    repeat (2) cyc(0, 1, 0, 0, '0);
    repeat (4) cyc(0, 1, 1, 0, '0);
    repeat (2) cyc(0, 1, 0, 0, '0);
    repeat (2) cyc(0, 1, 1, 0, '0);
    repeat (2) cyc(0, 1, 0, 0, '0);
    // release with a step edge in the same cycle
    cyc(0, 0, 1, 0, '0);
    repeat (2) cyc(0, 0, 0, 0, '0);
    // halt with pause in the same cycle wins
    cyc(0, 1, 0, 1, '0);
    repeat (3) cyc(0, 1, 0, 0, '0);
    cyc(1, 0, 0, 0, 5'h0a);
    // long run: watchdog stop or counter saturation
    repeat (45) cyc(0, 0, 0, 0, '0);
    // restart then async reset mid-run with a step pending
    cyc(1, 1, 0, 0, 5'h13);
    repeat (4) cyc(0, 1, 0, 0, '0);
    cyc(0, 1, 1, 0, '0);
    do_reset(2);
    repeat (2) cyc(0, 0, 0, 0, '0);
    // randomized traffic
    p_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) p_lvl = ~p_lvl;
      if ($urandom_range(0, 499) == 0) do_reset($urandom_range(1, 3));
      else cyc($urandom_range(0, 5) == 0, p_lvl, $urandom_range(0, 2) == 0,
               $urandom_range(0, 29) == 0, MODE_W'($urandom));
    end
    @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
